// File: rtl/ps2_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ps2_pkg
// Description : Shared types and constants for the PS/2 receive path:
//               receiver state encoding, default filter/watchdog sizing,
//               frame length and the odd-parity helper.
// Revision    : 1.0 - initial release
// ============================================================================
package ps2_pkg;

    // Filtered-level debounce depth and idle-clock watchdog (100 us @ 50 MHz)
    localparam int unsigned c_filter_len_default  = 8;
    localparam int unsigned c_timeout_cyc_default = 5000;

    // Start + 8 data + parity + stop
    localparam int unsigned c_frame_len = 11;

    // Receiver state encoding, explicit 2-bit width
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DATA   = 2'd1,
        ST_PARITY = 2'd2,
        ST_STOP   = 2'd3
    } ps2_state_t;

    // PS/2 uses odd parity: data bits XOR parity bit must be 1
    function automatic logic frame_parity_ok(input logic [7:0] data, input logic par);
        return ^{data, par};
    endfunction

endpackage : ps2_pkg
`default_nettype wire

// File: rtl/ps2_line_filter.sv
`default_nettype none
// ============================================================================
// Module      : ps2_line_filter
// Description : Two-flop synchronizer followed by a glitch filter. The output
//               only changes after FILTER_LEN consecutive synchronized samples
//               that disagree with it. Resets to the idle (high) line level.
// Revision    : 1.0 - initial release
// ============================================================================
module ps2_line_filter
    import ps2_pkg::*;
#(
    parameter int unsigned FILTER_LEN = c_filter_len_default
) (
    input  logic clk,
    input  logic rst,      // synchronous, active-low
    input  logic i_line,   // asynchronous raw line
    output logic o_line    // synchronized, filtered level
);

    localparam int unsigned        c_cnt_w = $clog2(FILTER_LEN + 1);
    localparam logic [c_cnt_w-1:0] c_last  = c_cnt_w'(FILTER_LEN - 1);

    logic [1:0]         r_sync;
    logic [c_cnt_w-1:0] r_cnt;
    logic               r_line;

    // Synchronize, then count consecutive samples differing from the output
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_sync <= 2'b11;
            r_cnt  <= '0;
            r_line <= 1'b1;
        end else begin
            r_sync <= {r_sync[0], i_line};
            if (r_sync[1] == r_line) begin
                r_cnt <= '0;
            end else if (r_cnt == c_last) begin
                r_line <= r_sync[1];
                r_cnt  <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign o_line = r_line;

endmodule : ps2_line_filter
`default_nettype wire

// File: rtl/ps2_rx_frame.sv
`default_nettype none
// ============================================================================
// Module      : ps2_rx_frame
// Description : PS/2 keyboard frame receiver. Filters the PS/2 clock and data
//               lines, samples data on filtered clock falling edges, checks
//               odd parity and stop bit, and guards against a stalled clock
//               with an idle watchdog.
// Revision    : 1.0 - initial release
// ============================================================================
module ps2_rx_frame
    import ps2_pkg::*;
#(
    parameter int unsigned FILTER_LEN  = c_filter_len_default,
    parameter int unsigned TIMEOUT_CYC = c_timeout_cyc_default
) (
    input  logic       clk,
    input  logic       rst,          // synchronous, active-low
    input  logic       ps2c,
    input  logic       ps2d,
    output logic [7:0] scan_code,
    output logic       code_valid,
    output logic       frame_err,
    output logic       busy
);

    localparam int unsigned         c_wdog_w        = $clog2(TIMEOUT_CYC + 1);
    localparam logic [c_wdog_w-1:0] c_wdog_limit    = c_wdog_w'(TIMEOUT_CYC);
    // Index of the last data bit: frame minus start, parity, stop, minus one
    localparam logic [2:0]          c_last_data_bit = 3'(c_frame_len - 4);

    logic                w_ps2c_f;
    logic                w_ps2d_f;
    logic                r_ps2c_prev;
    logic                w_fall;
    logic                w_timeout;
    logic                w_accept;
    logic                w_reject;
    ps2_state_t          r_state;
    ps2_state_t          w_state_next;
    logic [7:0]          r_shift;
    logic [2:0]          r_bitcnt;
    logic                r_parity;
    logic [c_wdog_w-1:0] r_wdog;
    logic [7:0]          r_scan_code;
    logic                r_code_valid;
    logic                r_frame_err;

    ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_filt_clk (
        .clk    (clk),
        .rst    (rst),
        .i_line (ps2c),
        .o_line (w_ps2c_f)
    );

    ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_filt_dat (
        .clk    (clk),
        .rst    (rst),
        .i_line (ps2d),
        .o_line (w_ps2d_f)
    );

    assign w_fall    = r_ps2c_prev & ~w_ps2c_f;
    // Timeout takes priority over any edge arriving in the same cycle
    assign w_timeout = (r_state != ST_IDLE) && (r_wdog == c_wdog_limit);

    // State register
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic: advance one state per filtered falling edge
    always_comb begin
        w_state_next = r_state;
        if (w_timeout) begin
            w_state_next = ST_IDLE;
        end else if (w_fall) begin
            case (r_state)
                ST_IDLE:   if (!w_ps2d_f) w_state_next = ST_DATA;
                ST_DATA:   if (r_bitcnt == c_last_data_bit) w_state_next = ST_PARITY;
                ST_PARITY: w_state_next = ST_STOP;
                ST_STOP:   w_state_next = ST_IDLE;
                default:   w_state_next = ST_IDLE;
            endcase
        end
    end

    // Output decode: busy level and frame accept/reject on the stop edge
    always_comb begin
        busy     = (r_state != ST_IDLE);
        w_accept = 1'b0;
        w_reject = 1'b0;
        if ((r_state == ST_STOP) && w_fall && !w_timeout) begin
            if (frame_parity_ok(r_shift, r_parity) && w_ps2d_f) begin
                w_accept = 1'b1;
            end else begin
                w_reject = 1'b1;
            end
        end
    end

    // Datapath: edge history, shifter, parity, watchdog and result registers
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_ps2c_prev  <= 1'b1;
            r_shift      <= '0;
            r_bitcnt     <= '0;
            r_parity     <= 1'b0;
            r_wdog       <= '0;
            r_scan_code  <= '0;
            r_code_valid <= 1'b0;
            r_frame_err  <= 1'b0;
        end else begin
            r_ps2c_prev  <= w_ps2c_f;
            r_code_valid <= w_accept;
            r_frame_err  <= w_reject | w_timeout;

            if (w_accept) begin
                r_scan_code <= r_shift;
            end

            if (w_fall || w_timeout) begin
                r_wdog <= '0;
            end else if (r_state != ST_IDLE) begin
                r_wdog <= r_wdog + 1'b1;
            end

            if (w_timeout) begin
                // Discard the partial byte
                r_shift  <= '0;
                r_bitcnt <= '0;
            end else if (w_fall) begin
                case (r_state)
                    ST_IDLE: r_bitcnt <= '0;
                    ST_DATA: begin
                        r_shift  <= {w_ps2d_f, r_shift[7:1]};
                        r_bitcnt <= r_bitcnt + 1'b1;
                    end
                    ST_PARITY: r_parity <= w_ps2d_f;
                    default: ;
                endcase
            end
        end
    end

    assign scan_code  = r_scan_code;
    assign code_valid = r_code_valid;
    assign frame_err  = r_frame_err;

endmodule : ps2_rx_frame
`default_nettype wire

// File: tb/tb_ps2_rx_frame.sv
`default_nettype none
// ============================================================================
// Module      : tb_ps2_rx_frame
// Description : Directed self-checking bench for ps2_rx_frame. PS/2 bit
//               period is 40 clk cycles and the watchdog is shortened to 200
//               cycles to keep the run short.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ps2_rx_frame;

    localparam int unsigned c_timeout = 200;

    logic       clk  = 1'b0;
    logic       rst  = 1'b0;
    logic       ps2c = 1'b1;
    logic       ps2d = 1'b1;
    logic [7:0] scan_code;
    logic       code_valid;
    logic       frame_err;
    logic       busy;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int cv_cnt = 0;
    int fe_cnt = 0;
    int both_cnt = 0;
    int t_fall = 0;
    int t_fe   = 0;
    logic [7:0] cv_log [0:15];

    ps2_rx_frame #(.FILTER_LEN(8), .TIMEOUT_CYC(c_timeout)) dut (
        .clk        (clk),
        .rst        (rst),
        .ps2c       (ps2c),
        .ps2d       (ps2d),
        .scan_code  (scan_code),
        .code_valid (code_valid),
        .frame_err  (frame_err),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Count pulse cycles and log received codes, sampled mid-cycle
    always @(negedge clk) begin
        if (code_valid === 1'b1) begin
            cv_log[cv_cnt % 16] = scan_code;
            cv_cnt++;
        end
        if (frame_err === 1'b1) begin
            fe_cnt++;
            t_fe = cyc;
        end
        if (code_valid === 1'b1 && frame_err === 1'b1) both_cnt++;
    end

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_bit(input logic b);
        ps2d = b;
        wait_cyc(10);
        ps2c = 1'b0;
        t_fall = cyc;
        wait_cyc(20);
        ps2c = 1'b1;
        wait_cyc(10);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic par, input logic stp);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
        send_bit(par);
        send_bit(stp);
        ps2d = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        wait_cyc(3);
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
        total++; if (scan_code !== 8'h00) begin bad++; $display("FAIL reset_scan got=%h want=00", scan_code); end
        total++; if (code_valid !== 1'b0) begin bad++; $display("FAIL reset_cv got=%b want=0", code_valid); end
        total++; if (frame_err !== 1'b0) begin bad++; $display("FAIL reset_fe got=%b want=0", frame_err); end
        rst = 1'b1;
        wait_cyc(5);
    endtask

    task automatic test_good_frame();
        int c0 = cv_cnt;
        int f0 = fe_cnt;
        send_frame(8'h1C, 1'b0, 1'b1);
        wait_cyc(20);
        total++; if (cv_cnt - c0 != 1) begin bad++; $display("FAIL good_cv_count got=%0d want=1", cv_cnt - c0); end
        total++; if (fe_cnt - f0 != 0) begin bad++; $display("FAIL good_fe_count got=%0d want=0", fe_cnt - f0); end
        total++; if (scan_code !== 8'h1C) begin bad++; $display("FAIL good_scan got=%h want=1c", scan_code); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL good_busy got=%b want=0", busy); end
    endtask

    task automatic test_patterns();
        logic [7:0] pat_d [0:4];
        logic       pat_p [0:4];
        pat_d = '{8'h55, 8'h01, 8'h00, 8'hFF, 8'h80};
        pat_p = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        for (int k = 0; k < 5; k++) begin
            int c0 = cv_cnt;
            send_frame(pat_d[k], pat_p[k], 1'b1);
            wait_cyc(20);
            total++; if (cv_cnt - c0 != 1) begin bad++; $display("FAIL pat%0d_cv_count got=%0d want=1", k, cv_cnt - c0); end
            total++; if (scan_code !== pat_d[k]) begin bad++; $display("FAIL pat%0d_scan got=%h want=%h", k, scan_code, pat_d[k]); end
        end
    endtask

    task automatic test_parity_err();
        int c0 = cv_cnt;
        int f0 = fe_cnt;
        send_frame(8'h1C, 1'b1, 1'b1);
        wait_cyc(20);
        total++; if (fe_cnt - f0 != 1) begin bad++; $display("FAIL par_fe_count got=%0d want=1", fe_cnt - f0); end
        total++; if (cv_cnt - c0 != 0) begin bad++; $display("FAIL par_cv_count got=%0d want=0", cv_cnt - c0); end
        total++; if (scan_code !== 8'h80) begin bad++; $display("FAIL par_scan got=%h want=80", scan_code); end
    endtask

    task automatic test_stop_err();
        int c0 = cv_cnt;
        int f0 = fe_cnt;
        send_frame(8'hF0, 1'b1, 1'b0);
        wait_cyc(20);
        total++; if (fe_cnt - f0 != 1) begin bad++; $display("FAIL stop_fe_count got=%0d want=1", fe_cnt - f0); end
        total++; if (cv_cnt - c0 != 0) begin bad++; $display("FAIL stop_cv_count got=%0d want=0", cv_cnt - c0); end
        total++; if (scan_code !== 8'h80) begin bad++; $display("FAIL stop_scan got=%h want=80", scan_code); end
        c0 = cv_cnt;
        f0 = fe_cnt;
        send_frame(8'hF0, 1'b1, 1'b1);
        wait_cyc(20);
        total++; if (cv_cnt - c0 != 1) begin bad++; $display("FAIL stop_retry_cv got=%0d want=1", cv_cnt - c0); end
        total++; if (fe_cnt - f0 != 0) begin bad++; $display("FAIL stop_retry_fe got=%0d want=0", fe_cnt - f0); end
        total++; if (scan_code !== 8'hF0) begin bad++; $display("FAIL stop_retry_scan got=%h want=f0", scan_code); end
    endtask

    task automatic test_timeout();
        int c0 = cv_cnt;
        int f0 = fe_cnt;
        int tf;
        int dt;
        send_bit(1'b0);
        send_bit(1'b0);
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b1);
        tf = t_fall;
        wait_cyc(300);
        dt = t_fe - tf;
        total++; if (fe_cnt - f0 != 1) begin bad++; $display("FAIL tmo_fe_count got=%0d want=1", fe_cnt - f0); end
        total++; if (cv_cnt - c0 != 0) begin bad++; $display("FAIL tmo_cv_count got=%0d want=0", cv_cnt - c0); end
        total++; if (dt < 200 || dt > 230) begin bad++; $display("FAIL tmo_latency got=%0d want=200..230", dt); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL tmo_busy got=%b want=0", busy); end
        total++; if (scan_code !== 8'hF0) begin bad++; $display("FAIL tmo_scan_hold got=%h want=f0", scan_code); end
        c0 = cv_cnt;
        send_frame(8'h1C, 1'b0, 1'b1);
        wait_cyc(20);
        total++; if (cv_cnt - c0 != 1) begin bad++; $display("FAIL tmo_next_cv got=%0d want=1", cv_cnt - c0); end
        total++; if (scan_code !== 8'h1C) begin bad++; $display("FAIL tmo_next_scan got=%h want=1c", scan_code); end
    endtask

    task automatic test_glitch();
        int c0 = cv_cnt;
        int f0 = fe_cnt;
        logic [7:0] d;
        d = 8'h34;
        // Glitch while idle
        ps2c = 1'b0;
        wait_cyc(3);
        ps2c = 1'b1;
        wait_cyc(20);
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL glitch_idle_busy got=%b want=0", busy); end
        // Glitch mid-frame, during the clock-high phase
        send_bit(1'b0);
        for (int i = 0; i < 3; i++) send_bit(d[i]);
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL glitch_mid_busy got=%b want=1", busy); end
        ps2c = 1'b0;
        wait_cyc(3);
        ps2c = 1'b1;
        wait_cyc(10);
        for (int i = 3; i < 8; i++) send_bit(d[i]);
        send_bit(1'b0);
        send_bit(1'b1);
        ps2d = 1'b1;
        wait_cyc(20);
        total++; if (cv_cnt - c0 != 1) begin bad++; $display("FAIL glitch_cv_count got=%0d want=1", cv_cnt - c0); end
        total++; if (fe_cnt - f0 != 0) begin bad++; $display("FAIL glitch_fe_count got=%0d want=0", fe_cnt - f0); end
        total++; if (scan_code !== 8'h34) begin bad++; $display("FAIL glitch_scan got=%h want=34", scan_code); end
    endtask

    task automatic test_back_to_back();
        int c0 = cv_cnt;
        int f0 = fe_cnt;
        send_frame(8'h12, 1'b1, 1'b1);
        send_frame(8'hA7, 1'b0, 1'b1);
        wait_cyc(20);
        total++; if (cv_cnt - c0 != 2) begin bad++; $display("FAIL b2b_cv_count got=%0d want=2", cv_cnt - c0); end
        total++; if (fe_cnt - f0 != 0) begin bad++; $display("FAIL b2b_fe_count got=%0d want=0", fe_cnt - f0); end
        total++; if (cv_log[c0 % 16] !== 8'h12) begin bad++; $display("FAIL b2b_first got=%h want=12", cv_log[c0 % 16]); end
        total++; if (cv_log[(c0 + 1) % 16] !== 8'hA7) begin bad++; $display("FAIL b2b_second got=%h want=a7", cv_log[(c0 + 1) % 16]); end
    endtask

    task automatic test_reset_midframe();
        int c0 = cv_cnt;
        int f0 = fe_cnt;
        for (int i = 0; i < 5; i++) send_bit(1'b0);
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL rstmid_pre_busy got=%b want=1", busy); end
        rst = 1'b0;
        wait_cyc(2);
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL rstmid_busy got=%b want=0", busy); end
        total++; if (scan_code !== 8'h00) begin bad++; $display("FAIL rstmid_scan got=%h want=00", scan_code); end
        total++; if (code_valid !== 1'b0 || frame_err !== 1'b0) begin bad++; $display("FAIL rstmid_pulses got=%b%b want=00", code_valid, frame_err); end
        rst = 1'b1;
        wait_cyc(300);
        total++; if (cv_cnt - c0 != 0 || fe_cnt - f0 != 0) begin bad++; $display("FAIL rstmid_no_pulse got=%0d/%0d want=0/0", cv_cnt - c0, fe_cnt - f0); end
        c0 = cv_cnt;
        send_frame(8'hF0, 1'b1, 1'b1);
        wait_cyc(20);
        total++; if (cv_cnt - c0 != 1) begin bad++; $display("FAIL rstmid_next_cv got=%0d want=1", cv_cnt - c0); end
        total++; if (scan_code !== 8'hF0) begin bad++; $display("FAIL rstmid_next_scan got=%h want=f0", scan_code); end
    endtask

    task automatic test_exclusive();
        total++; if (both_cnt != 0) begin bad++; $display("FAIL cv_fe_overlap got=%0d want=0", both_cnt); end
    endtask

    initial begin
        test_reset();
        test_good_frame();
        test_patterns();
        test_parity_err();
        test_stop_err();
        test_timeout();
        test_glitch();
        test_back_to_back();
        test_reset_midframe();
        test_exclusive();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_ps2_rx_frame
`default_nettype wire

// File: doc/ps2_rx_frame.md
PS2_RX_FRAME -- requirements
Module: ps2_rx_frame

Interface
REQ-001 Parameter FILTER_LEN, default 8, is the number of consecutive equal samples that declares a new filtered line level.
REQ-002 Parameter TIMEOUT_CYC, default 5000, is the idle-clock watchdog limit (100 us at 50 MHz).
REQ-003 The block SHALL use one clock and a synchronous, active-low reset:
  clk  input  1  system clock, 50 MHz, rising edge
  rst  input  1  synchronous active-low reset
REQ-004 The remaining ports SHALL be:
  ps2c  input  1  raw PS/2 clock from keyboard, asynchronous
  ps2d  input  1  raw PS/2 data from keyboard, asynchronous
  scan_code  output  8  last good received byte
  code_valid  output  1  one-cycle pulse: scan_code newly updated
  frame_err  output  1  one-cycle pulse: frame dropped (parity, stop, or timeout)
  busy  output  1  high while a frame is in progress

Function
REQ-005 ps2c and ps2d SHALL each pass through a 2-flop synchronizer, then a filter that changes its output only after FILTER_LEN consecutive equal synchronized samples.
REQ-006 A falling edge SHALL be detected as filtered ps2c 1 in the previous cycle and 0 in the current cycle, and the filtered ps2d SHALL be sampled in that same cycle.
REQ-007 The FSM states SHALL be IDLE, DATA, PARITY, STOP.
REQ-008 IDLE transitions to DATA on a falling edge with sampled data 0; a falling edge with data 1 is ignored and the state stays IDLE.
REQ-009 DATA shifts in 8 bits LSB first, then transitions to PARITY.
REQ-010 PARITY captures the parity bit, then transitions to STOP.
REQ-011 STOP, on its falling edge, returns to IDLE.
REQ-012 The frame SHALL be accepted only if the XOR of the 8 data bits and the parity bit is 1 (odd parity) and the stop bit is 1.
REQ-013 On acceptance, in the cycle after the stop-bit edge, scan_code SHALL load the byte and code_valid SHALL pulse for exactly 1 cycle.
REQ-014 On rejection, scan_code SHALL hold its value, code_valid SHALL stay 0, and frame_err SHALL pulse for 1 cycle.
REQ-015 The watchdog counter SHALL clear on every falling edge and increment each cycle while the state is not IDLE.
REQ-016 When the watchdog reaches TIMEOUT_CYC, the FSM SHALL return to IDLE, discard the partial byte and pulse frame_err; code_valid SHALL stay 0.
REQ-017 busy SHALL be 1 exactly when the state is not IDLE.
REQ-018 code_valid and frame_err SHALL never be asserted in the same cycle.
REQ-019 A filtered falling edge coinciding with the timeout cycle SHALL be handled as the timeout; that edge is not used as a start bit.
REQ-020 Back-to-back frames with no idle time after the stop bit SHALL be received without loss.

Reset
REQ-021 While rst=0 at a clk edge, the block SHALL be in reset: state IDLE, scan_code 0x00, code_valid 0, frame_err 0, busy 0, watchdog and bit counter 0.
REQ-022 In reset, filter outputs SHALL be set to 1 (idle line) and synchronizer flops SHALL be set to 1.
REQ-023 Reset asserted mid-frame SHALL abort the frame with no code_valid or frame_err pulse.
REQ-024 After release, the first clean frame SHALL be received normally.

Structure
REQ-025 Package ps2_pkg SHALL hold the state enum type, the FILTER_LEN and TIMEOUT_CYC defaults, and the frame length constant (11).
REQ-026 Sub-module ps2_line_filter (synchronizer plus glitch filter) SHALL be instantiated twice, once for ps2c and once for ps2d.
REQ-027 The FSM, shifter, parity check and watchdog SHALL be in ps2_rx_frame; its output feeds the scan-code decoder in top.

Verification
REQ-028 Good frame: send 0x1C with bits 0,0,0,1,1,1,0,0,0,0,1, 40 us PS/2 period -> one code_valid pulse, scan_code=0x1C, frame_err never high.
REQ-029 Parity error: send 0x1C with parity bit 1 -> frame_err pulse, scan_code unchanged, no code_valid.
REQ-030 Stop error: send 0xF0 (parity 1) with stop bit 0 -> frame_err pulse; then send 0xF0 correctly -> code_valid, scan_code=0xF0.
REQ-031 Timeout: send start plus 4 data bits, then hold ps2c high 120 us -> frame_err pulse about 100 us after the last edge and busy=0; a following 0x1C frame is received correctly.
REQ-032 Glitch: 3-cycle low pulses on ps2c in IDLE and mid-frame -> no state change, and the next frame decodes to the correct value.
REQ-033 Reset mid-frame: pull rst low after 5 bits for 2 cycles -> all outputs at reset values, no pulses; a subsequent 0xF0 frame -> scan_code=0xF0.
